// File: rtl/voice_pkg.sv
// Shared types and constants for the voice crossfader.
package voice_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int RAMP_LOG2_DEFAULT = 8;

  typedef enum logic [1:0] {
    DRY      = 2'd0,
    FADE_IN  = 2'd1,
    WET      = 2'd2,
    FADE_OUT = 2'd3
  } xfade_state_t;

  function automatic logic is_fading(input xfade_state_t s);
    return (s == FADE_IN) || (s == FADE_OUT);
  endfunction

endpackage

// File: rtl/voice_xfade_mac.sv
// Stage-2 datapath of the crossfader: wet*g + dry*(N-g), optional rounding
// bias, arithmetic shift by RAMP_LOG2, registered output and valid strobe.
// Optional feature macro: VOICE_XFADE_ROUND_EN (round half up instead of floor).
module voice_xfade_mac #(
  parameter int SAMPLE_W  = voice_pkg::SAMPLE_W,
  parameter int RAMP_LOG2 = voice_pkg::RAMP_LOG2_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] dry_in,
  input  logic signed [SAMPLE_W-1:0] wet_in,
  input  logic        [RAMP_LOG2:0]  g_in,
  output logic signed [SAMPLE_W-1:0] mix_out,
  output logic                       mix_valid
);

  localparam int GW = RAMP_LOG2 + 1;       // gain width, holds 0..N
  localparam int PW = SAMPLE_W + GW + 1;   // product/sum width with headroom
  localparam logic [GW-1:0] N_GAIN = {1'b1, {RAMP_LOG2{1'b0}}};

`ifdef VOICE_XFADE_ROUND_EN
  localparam logic signed [PW-1:0] BIAS =
    {{(PW-RAMP_LOG2){1'b0}}, 1'b1, {(RAMP_LOG2-1){1'b0}}};
`else
  localparam logic signed [PW-1:0] BIAS = '0;
`endif

  logic signed [GW:0]          g_s;
  logic signed [GW:0]          h_s;
  logic signed [PW-1:0]        wet_p;
  logic signed [PW-1:0]        dry_p;
  logic signed [PW-1:0]        acc;
  logic signed [SAMPLE_W-1:0]  mix_d, mix_q;
  logic                        valid_d, valid_q;

  // Weighted sum of the two samples; the weights always add to N, so the
  // shifted result is guaranteed to fit SAMPLE_W without saturation.
  always_comb begin
    // NOTE: every always_comb output is assigned on all paths (here up front)
    // so no latch is inferred.
    g_s     = $signed({1'b0, g_in});
    h_s     = $signed({1'b0, N_GAIN - g_in});
    wet_p   = PW'(wet_in) * PW'(g_s);
    dry_p   = PW'(dry_in) * PW'(h_s);
    acc     = wet_p + dry_p + BIAS;
    mix_d   = in_valid ? SAMPLE_W'(acc >>> RAMP_LOG2) : mix_q;
    valid_d = in_valid;
  end

  // Output register: mix holds between frames, valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      mix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mix_q   <= mix_d;
      valid_q <= valid_d;
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = valid_q;

endmodule

// File: rtl/voice_xfade.sv
// Click-free dry/wet crossfader. A gain counter g ramps one step per audio
// frame toward 0 (dry) or N = 2^RAMP_LOG2 (wet); stage 1 captures the
// samples with the pre-update gain, stage 2 (voice_xfade_mac) mixes them.
// Optional feature macro: VOICE_XFADE_ROUND_EN (handled in voice_xfade_mac).
module voice_xfade #(
  parameter int SAMPLE_W  = voice_pkg::SAMPLE_W,
  parameter int RAMP_LOG2 = voice_pkg::RAMP_LOG2_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] dry_in,
  input  logic signed [SAMPLE_W-1:0] wet_in,
  input  logic                       change_en,
  output logic signed [SAMPLE_W-1:0] mix_out,
  output logic                       mix_valid,
  output logic                       busy,
  output logic        [RAMP_LOG2:0]  gain
);

  import voice_pkg::*;

  localparam int GW = RAMP_LOG2 + 1;
  localparam logic [GW-1:0] N_GAIN = {1'b1, {RAMP_LOG2{1'b0}}};

  xfade_state_t               state_q, state_d;
  logic [GW-1:0]              g_q, g_d;
  logic [GW-1:0]              target;
  logic                       busy_q, busy_d;

  logic                       s1_valid_q, s1_valid_d;
  logic signed [SAMPLE_W-1:0] s1_dry_q, s1_dry_d;
  logic signed [SAMPLE_W-1:0] s1_wet_q, s1_wet_d;
  logic [GW-1:0]              s1_g_q, s1_g_d;

  // Next-state, gain step and stage-1 capture; everything moves only on a frame strobe.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    busy_d     = busy_q;
    s1_valid_d = sample_ready;
    s1_dry_d   = s1_dry_q;
    s1_wet_d   = s1_wet_q;
    s1_g_d     = s1_g_q;
    target     = change_en ? N_GAIN : '0;

    if (sample_ready) begin
      // The mix for this frame uses the gain before this frame's step.
      s1_dry_d = dry_in;
      s1_wet_d = wet_in;
      s1_g_d   = g_q;

      if (g_q < target) begin
        g_d     = g_q + GW'(1);
        state_d = FADE_IN;
      end else if (g_q > target) begin
        g_d     = g_q - GW'(1);
        state_d = FADE_OUT;
      end else begin
        state_d = change_en ? WET : DRY;
      end
      busy_d = is_fading(state_d);
    end
  end

  // FSM state, gain counter and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DRY;
      g_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
    end
  end

  // Stage-1 pipeline registers; clearing valid here drops any in-flight frame on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_dry_q   <= '0;
      s1_wet_q   <= '0;
      s1_g_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dry_q   <= s1_dry_d;
      s1_wet_q   <= s1_wet_d;
      s1_g_q     <= s1_g_d;
    end
  end

  voice_xfade_mac #(
    .SAMPLE_W (SAMPLE_W),
    .RAMP_LOG2(RAMP_LOG2)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s1_valid_q),
    .dry_in   (s1_dry_q),
    .wet_in   (s1_wet_q),
    .g_in     (s1_g_q),
    .mix_out  (mix_out),
    .mix_valid(mix_valid)
  );

  assign busy = busy_q;
  assign gain = g_q;

endmodule

// File: tb/tb_voice_xfade.sv
// Self-checking bench for voice_xfade: table-driven strobe phases with a
// scoreboard of expected mixes (value and arrival cycle), plus hand-written
// reset-mid-fade sequence.
module tb_voice_xfade;

  localparam int SW = 16;
  localparam int RL = 8;
  localparam int NG = 1 << RL;

  logic                 clk;
  logic                 reset;
  logic                 sample_ready;
  logic signed [SW-1:0] dry_in;
  logic signed [SW-1:0] wet_in;
  logic                 change_en;
  logic signed [SW-1:0] mix_out;
  logic                 mix_valid;
  logic                 busy;
  logic [RL:0]          gain;

  voice_xfade #(.SAMPLE_W(SW), .RAMP_LOG2(RL)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_ready(sample_ready),
    .dry_in      (dry_in),
    .wet_in      (wet_in),
    .change_en   (change_en),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .gain        (gain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference mix: integer arithmetic, floor division by N (optionally +N/2 first).
  function automatic longint mix_model(input longint d, input longint w, input longint g);
    longint s;
    s = w * g + d * (NG - g);
`ifdef VOICE_XFADE_ROUND_EN
    s = s + (NG / 2);
`endif
    return s >>> RL;
  endfunction

  typedef struct {
    longint mix;
    int     due;
  } exp_t;

  exp_t   sb[$];
  int     ncnt   = 0;
  int     m_g    = 0;
  logic   m_busy = 1'b0;
  longint last_mix = 0;

  // Monitor on the falling edge: compare gain/busy to the model, pop and
  // compare each mix pulse, then enqueue the expectation for any strobe seen now.
  always @(negedge clk) begin
    exp_t e;
    int   tgt;
    ncnt++;
    if (!reset) begin
      sb.delete();
      m_g    = 0;
      m_busy = 1'b0;
      check("rst_valid", mix_valid, 0);
      check("rst_mix", mix_out, 0);
      check("rst_gain", gain, 0);
    end else begin
      check("gain", gain, m_g);
      check("busy", busy, m_busy);
      if (mix_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("mix", mix_out, e.mix);
          check("latency", ncnt, e.due);
          last_mix = mix_out;
        end
      end
      while (sb.size() > 0 && sb[0].due < ncnt) begin
        e = sb.pop_front();
        check("missing_valid", 0, 1);
      end
      if (sample_ready) begin
        e.mix = mix_model(dry_in, wet_in, m_g);
        e.due = ncnt + 2;
        sb.push_back(e);
        tgt = change_en ? NG : 0;
        if (m_g < tgt) begin
          m_g++;
          m_busy = 1'b1;
        end else if (m_g > tgt) begin
          m_g--;
          m_busy = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int   n;         // strobes in this phase
    int   gap;       // idle cycles after each strobe (0 = back-to-back)
    logic ce;
    int   dry;
    int   wet;
    int   exp_gain;  // gain after the phase
    logic exp_busy;  // busy after the phase
    logic chk_mix;   // check mix of the last strobe
    int   exp_mix;
  } vec_t;

  vec_t tbl[24];

  task automatic run_phase(input int idx, input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      dry_in       = 16'(v.dry);
      wet_in       = 16'(v.wet);
      change_en    = v.ce;
      sample_ready = 1'b1;
      @(posedge clk); #1;
      if (v.gap > 0) begin
        // Between strobes every input is noise and change_en is inverted.
        sample_ready = 1'b0;
        change_en    = ~v.ce;
        dry_in       = 16'($urandom);
        wet_in       = 16'($urandom);
        repeat (v.gap) begin
          @(posedge clk); #1;
        end
      end
    end
    sample_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check($sformatf("phase%0d_gain", idx), gain, v.exp_gain);
    check($sformatf("phase%0d_busy", idx), busy, v.exp_busy);
    if (v.chk_mix) check($sformatf("phase%0d_mix", idx), last_mix, v.exp_mix);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //        n   gap ce  dry     wet    gain busy chk mix
    tbl[0]  = '{10,  1, 0,  1000,  -1000,   0, 0, 1,  1000};
    tbl[1]  = '{128, 1, 1,  1000,  -1000, 128, 1, 0,     0};
    tbl[2]  = '{1,   1, 1,  1000,  -1000, 129, 1, 1,     0};
    tbl[3]  = '{127, 1, 1,  1000,  -1000, 256, 1, 0,     0};
    tbl[4]  = '{1,   1, 1,  1000,  -1000, 256, 0, 1, -1000};
    tbl[5]  = '{2,   1, 1,  1000,  -1000, 256, 0, 1, -1000};
    tbl[6]  = '{256, 1, 0,  1000,  -1000,   0, 1, 1,   992};
    tbl[7]  = '{1,   1, 0,  1000,  -1000,   0, 0, 1,  1000};
    tbl[8]  = '{100, 0, 1,  1000,  -1000, 100, 1, 0,     0};
    tbl[9]  = '{1,   1, 0,  1000,  -1000,  99, 1, 0,     0};
    tbl[10] = '{39,  1, 0,  1000,  -1000,  60, 1, 1,   523};
    tbl[11] = '{68,  1, 1,  32767,  32767, 128, 1, 1, 32767};
    tbl[12] = '{1,   1, 1,  32767,  32767, 129, 1, 1, 32767};
    tbl[13] = '{126, 0, 1,  32767,  32767, 255, 1, 1, 32767};
    tbl[14] = '{1,   1, 1,  32767,  32767, 256, 1, 1, 32767};
    tbl[15] = '{1,   1, 0, -32768, -32768, 255, 1, 1, -32768};
    tbl[16] = '{1,   1, 0, -32768, -32768, 254, 1, 1, -32768};
    tbl[17] = '{252, 1, 0, -32768, -32768,   2, 1, 1, -32768};
    tbl[18] = '{1,   1, 0,  32767,  32767,   1, 1, 1, 32767};
    tbl[19] = '{1,   1, 0,  32767,  32767,   0, 1, 1, 32767};
    tbl[20] = '{1,   1, 0,  32767,  32767,   0, 0, 1, 32767};
    tbl[21] = '{1,   1, 1, -32768, -32768,   1, 1, 1, -32768};
    tbl[22] = '{1,   1, 1, -32768, -32768,   2, 1, 1, -32768};
    tbl[23] = '{58,  1, 1,  1000,  -1000,  60, 1, 0,     0};

    reset        = 1'b0;
    sample_ready = 1'b0;
    change_en    = 1'b0;
    dry_in       = '0;
    wet_in       = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("init_gain", gain, 0);
    check("init_busy", busy, 0);
    check("init_mix", mix_out, 0);
    check("init_valid", mix_valid, 0);

    foreach (tbl[i]) run_phase(i, tbl[i]);

    // Reset mid-fade at g=60 with a frame sitting in stage 1.
    dry_in       = 16'sd1000;
    wet_in       = -16'sd1000;
    change_en    = 1'b1;
    sample_ready = 1'b1;
    @(posedge clk); #1;
    sample_ready = 1'b0;
    check("pre_rst_gain", gain, 61);
    #2 reset = 1'b0;
    #1;
    check("async_rst_mix", mix_out, 0);
    check("async_rst_valid", mix_valid, 0);
    check("async_rst_gain", gain, 0);
    check("async_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("post_rst_gain", gain, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_queue", sb.size(), 0);

    // First frame after reset is plain dry.
    change_en    = 1'b0;
    sample_ready = 1'b1;
    @(posedge clk); #1;
    sample_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("post_rst_mix", last_mix, 1000);
    check("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_xfade.md
Name: voice_xfade

Overview:
Click-free crossfader between the dry codec sample and the pitch-shifted (wet) sample. Sits directly downstream of changevoice, in place of the hard ChangeEn mux. Its output drives LeftPlayData/RightPlayData as {mix_out, 8'd0}. When change_en toggles, a linear gain ramp runs over 2^RAMP_LOG2 sample frames instead of an instantaneous switch.

Parameters:
SAMPLE_W, 16, signed sample width of dry_in/wet_in/mix_out
RAMP_LOG2, 8, log2 of fade length in frames (N = 2^RAMP_LOG2; 256 frames ≈ 5.3 ms at 48 kHz)

Ports:
clk  in  1  system clock (sys_clk domain)
reset  in  1  asynchronous, active-low reset
sample_ready  in  1  one-cycle strobe, one per audio frame (the synchronised NewFrame "ready")
dry_in  in  SAMPLE_W  signed unprocessed sample (RightRecData[23:8])
wet_in  in  SAMPLE_W  signed changevoice SampleOut
change_en  in  1  level; 1 = wet requested, 0 = dry requested
mix_out  out  SAMPLE_W  signed crossfaded sample
mix_valid  out  1  one-cycle strobe, mix_out updated
busy  out  1  high while a fade is in progress
gain  out  RAMP_LOG2+1  current wet gain g, 0..N

Behaviour:
- Reset (reset=0, async): g=0, state DRY, mix_out=0, mix_valid=0, busy=0, pipeline registers cleared. No reset synchroniser inside; deassertion is handled at top level.
- States: DRY (g=0), FADE_IN, WET (g=N), FADE_OUT.
- On each sample_ready, target T = change_en ? N : 0:
  - g==T: hold; state = DRY or WET.
  - g<T: g+=1 after this frame; state FADE_IN.
  - g>T: g-=1 after this frame; state FADE_OUT.
- Reversal mid-fade (change_en flips during a fade): the direction changes on the next strobe with no jump in g.
- change_en is sampled only on sample_ready cycles. Changes between strobes have no effect until the next strobe.
- busy = state is FADE_IN or FADE_OUT, registered and updated with g.
- Pipeline:
  - Stage 1 (cycle t+1 after strobe at t): capture dry_in, wet_in, g_cur (g before its update), then update g/state.
  - Stage 2 (t+2): mix_out = (wet*g_cur + dry*(N-g_cur)) >>> RAMP_LOG2, arithmetic shift, floor. mix_valid=1 for exactly one cycle at t+2.
  - Latency: 2 clk.
- Width: products are SAMPLE_W+RAMP_LOG2+1 signed; the sum needs one more bit. Because g+(N-g)=N, the result always fits SAMPLE_W, so no saturation logic is needed.
- Back-to-back strobes, one per cycle, are legal. Each is fully pipelined, g steps once per strobe, and mix_valid follows each strobe.
- Inputs are sampled only in the strobe cycle. Values between strobes are don't-care.
- Reset mid-fade: immediate return to DRY, g=0, any in-flight mix_valid is dropped.

Optional Feature:
VOICE_XFADE_ROUND_EN
- Defined: add 2^(RAMP_LOG2-1) before the shift (round half up). Output is still provably in range: 32767 max, -32768 min.
- Undefined: truncation (floor) as above. Identical latency and ports either way.

Decomposition:
- Package voice_pkg: SAMPLE_W constant, xfade_state_t enum {DRY, FADE_IN, WET, FADE_OUT}, RAMP_LOG2 default.
- Sub-module voice_xfade_mac: stage-2 datapath (two signed multipliers, adder, optional round, shift, output register).
- FSM and gain counter stay in voice_xfade.

Test Plan:
- Reset, change_en=0, dry=1000, wet=-1000, 10 strobes -> mix_out=1000 each at t+2, gain=0, busy=0.
- Set change_en=1, dry=1000, wet=-1000, 257 strobes -> gain climbs 0..256; strobe with g=128 gives mix_out=0; busy=1 until g=256, then state WET and mix_out=-1000.
- Start a fade-in, drop change_en at g=100 -> next strobe uses g=100, then g=99, 98…; no step in mix_out; ends in DRY at g=0.
- Strobes on 5 consecutive cycles -> 5 consecutive mix_valid pulses from t+2, gain advanced by 5, each output computed with its own g.
- Extremes dry=wet=32767 and dry=wet=-32768 at g=1,128,255, both macro settings -> mix_out exactly 32767 / -32768, no wrap.
- Assert reset at g=60 with a strobe in flight -> outputs 0 immediately, no mix_valid, after release gain=0 and state DRY.
